// File: rtl/dht11_pkg.sv
// DHT11 shared definitions: FSM encoding, default protocol timing
// and the frame checksum helper used by the emulator, host reader and bench.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEAS_LOW,
    S_RESP_WAIT,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  localparam int D_START_MIN_US  = 18000;
  localparam int D_RESP_DELAY_US = 30;
  localparam int D_T_RESP_US     = 80;
  localparam int D_T_BIT_LOW_US  = 50;
  localparam int D_T_ZERO_US     = 27;
  localparam int D_T_ONE_US      = 70;

  function automatic logic [7:0] checksum(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    return 8'(a + b + c + d);
  endfunction

endpackage

// File: rtl/dht11_sensor_emulator_if.sv
// Payload/control bundle between the emulator and whoever
// supplies the reported readings.
interface dht11_sensor_emulator_if;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       corrupt_checksum;
  logic       mute;
  logic       busy;
  logic       frame_sent;

  modport master (
    output hum_int, hum_dec, temp_int, temp_dec,
    output corrupt_checksum, mute,
    input  busy, frame_sent
  );

  modport slave (
    input  hum_int, hum_dec, temp_int, temp_dec,
    input  corrupt_checksum, mute,
    output busy, frame_sent
  );
endinterface

// File: rtl/dht11_us_tick.sv
// One-clock enable every microsecond, divided down from the
// system clock.
module dht11_us_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 responder: detects the host start pulse and replies with
// the 80/80 us handshake and a 40-bit frame on an open-drain line.
module dht11_sensor_emulator
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_MIN_US  = D_START_MIN_US,
  parameter int RESP_DELAY_US = D_RESP_DELAY_US,
  parameter int T_RESP_US     = D_T_RESP_US,
  parameter int T_BIT_LOW_US  = D_T_BIT_LOW_US,
  parameter int T_ZERO_US     = D_T_ZERO_US,
  parameter int T_ONE_US      = D_T_ONE_US
) (
  input  logic clock,
  input  logic reset,
  inout  wire  dht11,
  dht11_sensor_emulator_if.slave cfg
);
  state_t      state, state_n;
  logic [1:0]  sync;
  logic        line;
  logic        tick;
  logic [15:0] us_cnt, us_n;
  logic [5:0]  bit_cnt, bit_n;
  logic [39:0] sreg, sreg_n;
  logic        drive_low, drv_n;
  logic        busy, busy_n;
  logic        sent, sent_n;
  logic [15:0] lim;
  logic        expire;
  logic [7:0]  csum;

  dht11_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign dht11          = drive_low ? 1'b0 : 1'bz;
  assign line           = sync[1];
  assign cfg.busy       = busy;
  assign cfg.frame_sent = sent;

  assign csum = checksum(cfg.hum_int, cfg.hum_dec,
                         cfg.temp_int, cfg.temp_dec)
              ^ {7'd0, cfg.corrupt_checksum};

  always_comb begin
    lim = 16'hFFFF;
    unique case (state)
      S_RESP_WAIT: lim = 16'(RESP_DELAY_US);
      S_RESP_LOW,
      S_RESP_HIGH: lim = 16'(T_RESP_US);
      S_BIT_LOW,
      S_END_LOW:   lim = 16'(T_BIT_LOW_US);
      S_BIT_HIGH:  lim = sreg[39] ? 16'(T_ONE_US)
                                  : 16'(T_ZERO_US);
      default:     lim = 16'hFFFF;
    endcase
  end

  assign expire = tick && (us_cnt == lim - 16'd1);

  always_comb begin
    state_n = state;
    us_n    = us_cnt;
    bit_n   = bit_cnt;
    sreg_n  = sreg;
    drv_n   = drive_low;
    busy_n  = busy;
    sent_n  = 1'b0;
    if (tick && us_cnt != 16'hFFFF) us_n = us_cnt + 16'd1;
    unique case (state)
      S_IDLE: begin
        drv_n = 1'b0;
        if (!line && !cfg.mute) begin
          us_n    = '0;
          state_n = S_MEAS_LOW;
        end
      end
      S_MEAS_LOW: if (line) begin
        us_n = '0;
        if (us_cnt >= 16'(START_MIN_US)) begin
          sreg_n  = {cfg.hum_int, cfg.hum_dec,
                     cfg.temp_int, cfg.temp_dec, csum};
          busy_n  = 1'b1;
          state_n = S_RESP_WAIT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RESP_WAIT: if (expire) begin
        us_n    = '0;
        drv_n   = 1'b1;
        state_n = S_RESP_LOW;
      end
      S_RESP_LOW: if (expire) begin
        us_n    = '0;
        drv_n   = 1'b0;
        state_n = S_RESP_HIGH;
      end
      S_RESP_HIGH: if (expire) begin
        us_n    = '0;
        drv_n   = 1'b1;
        bit_n   = '0;
        state_n = S_BIT_LOW;
      end
      S_BIT_LOW: if (expire) begin
        us_n    = '0;
        drv_n   = 1'b0;
        state_n = S_BIT_HIGH;
      end
      S_BIT_HIGH: if (expire) begin
        us_n    = '0;
        drv_n   = 1'b1;
        sreg_n  = {sreg[38:0], 1'b0};
        bit_n   = bit_cnt + 6'd1;
        state_n = (bit_cnt == 6'd39) ? S_END_LOW : S_BIT_LOW;
      end
      S_END_LOW: if (expire) begin
        us_n    = '0;
        drv_n   = 1'b0;
        sent_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        drv_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync      <= 2'b11;
      state     <= S_IDLE;
      us_cnt    <= '0;
      bit_cnt   <= '0;
      sreg      <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      sent      <= 1'b0;
    end else begin
      sync      <= {sync[0], dht11};
      state     <= state_n;
      us_cnt    <= us_n;
      bit_cnt   <= bit_n;
      sreg      <= sreg_n;
      drive_low <= drv_n;
      busy      <= busy_n;
      sent      <= sent_n;
    end
  end
endmodule
